// File: rtl/seq_divider_pkg.sv
// Shared divider definitions: datapath width, FSM state encoding and the
// operand constants that identify the special cases.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN_INT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/seq_divider_subtractor_nbit.sv
// N-bit subtractor returning the difference and the borrow out of the MSB.
module subtractor_nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] wide_s;

  assign wide_s     = {1'b0, a} - {1'b0, b};
  assign diff       = wide_s[N-1:0];
  assign borrow_out = wide_s[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for div/divu: one quotient bit per cycle,
// with divide-by-zero and signed-overflow short cuts straight to FIXUP.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH-1);

  div_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r, dvsr_r;
  logic             neg_q_r, neg_rem_r, pend_dbz_r, pend_ovf_r;
  logic             busy_r, done_r, dbz_r, ovf_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  logic [WIDTH:0]   shifted_s, sub_a_s, sub_b_s, sub_diff_s;
  logic             sub_borrow_s;
  logic [WIDTH-1:0] neg_b_s, neg_diff_s;
  logic             neg_borrow_s;
  logic             dbz_s, ovf_s, special_s;

  assign shifted_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};

  // Trial subtractor is shared: |dividend| in IDLE, trial in DIVIDE, -rem in FIXUP
  always_comb begin
    sub_a_s = shifted_s;
    sub_b_s = {1'b0, dvsr_r};
    case (state_r)
      IDLE: begin
        sub_a_s = {(WIDTH+1){1'b0}};
        sub_b_s = {1'b0, dividend};
      end
      DIVIDE: begin
        sub_a_s = shifted_s;
        sub_b_s = {1'b0, dvsr_r};
      end
      FIXUP: begin
        sub_a_s = {(WIDTH+1){1'b0}};
        sub_b_s = rem_r;
      end
      default: begin
        sub_a_s = shifted_s;
        sub_b_s = {1'b0, dvsr_r};
      end
    endcase
  end

  // Negator gives |divisor| in IDLE and -quotient in FIXUP
  assign neg_b_s = (state_r == IDLE) ? divisor : quo_r;

  subtractor_nbit #(.N(WIDTH + 1)) u_trial_sub (
    .a          (sub_a_s),
    .b          (sub_b_s),
    .diff       (sub_diff_s),
    .borrow_out (sub_borrow_s)
  );

  subtractor_nbit #(.N(WIDTH)) u_neg_sub (
    .a          ({WIDTH{1'b0}}),
    .b          (neg_b_s),
    .diff       (neg_diff_s),
    .borrow_out (neg_borrow_s)
  );

  // 0 - divisor borrows exactly when the divisor is non-zero
  assign dbz_s     = ~neg_borrow_s;
  assign ovf_s     = is_signed & (dividend == MIN_INT) & (divisor == ALL_ONES);
  assign special_s = dbz_s | ovf_s;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = special_s ? FIXUP : DIVIDE;
        end else begin
          state_s = IDLE;
        end
      end
      DIVIDE: begin
        if (cnt_r == LAST_ITER) begin
          state_s = FIXUP;
        end else begin
          state_s = DIVIDE;
        end
      end
      FIXUP:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, iteration datapath and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvsr_r      <= {WIDTH{1'b0}};
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      pend_dbz_r  <= 1'b0;
      pend_ovf_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r     <= 1'b1;
            dbz_r      <= 1'b0;
            ovf_r      <= 1'b0;
            pend_dbz_r <= dbz_s;
            pend_ovf_r <= ovf_s & ~dbz_s;
            neg_q_r    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_r  <= is_signed & dividend[WIDTH-1];
            rem_r      <= {(WIDTH+1){1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            if (special_s) begin
              quo_r  <= dividend;
              dvsr_r <= divisor;
            end else begin
              quo_r  <= (is_signed && dividend[WIDTH-1]) ? sub_diff_s[WIDTH-1:0] : dividend;
              dvsr_r <= (is_signed && divisor[WIDTH-1])  ? neg_diff_s : divisor;
            end
          end
        end
        DIVIDE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (!sub_borrow_s) begin
            rem_r <= sub_diff_s;
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s;
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
        end
        FIXUP: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          dbz_r  <= pend_dbz_r;
          ovf_r  <= pend_ovf_r;
          if (pend_dbz_r) begin
            quotient_r  <= ALL_ONES;
            remainder_r <= quo_r;
          end else if (pend_ovf_r) begin
            quotient_r  <= quo_r;
            remainder_r <= {WIDTH{1'b0}};
          end else begin
            quotient_r  <= neg_q_r   ? neg_diff_s            : quo_r;
            remainder_r <= neg_rem_r ? sub_diff_s[WIDTH-1:0] : rem_r[WIDTH-1:0];
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results come from a behavioural
// division model and are popped when done pulses.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          e0 = 0;
  int          busy_seen = 0;
  logic [31:0] last_q;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sv;
    e = '0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = 32'd0; e.ovf = 1'b1;
    end else if (sgn) begin
      sa = a; sv = b;
      e.q = 32'(sa / sv);
      e.r = 32'(sa % sv);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_seen++;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    sb.push_back(model(sgn, a, b));
    busy_seen = 0;
    tick();
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic await(input string tag, input int exp_lat);
    exp_t e;
    while (!done && (cyc - e0) < 100) tick();
    if (!done) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    check_eq({tag, "_latency"}, 32'(cyc - e0), 32'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 32'(busy_seen), 32'(exp_lat));
    check_eq({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      check_eq({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    last_q = e.q;
    check_eq({tag, "_quotient"}, quotient, e.q);
    check_eq({tag, "_remainder"}, remainder, e.r);
    check_eq({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
    check_eq({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_quotient"}, quotient, 32'd0);
    check_eq({tag, "_remainder"}, remainder, 32'd0);
    check_eq({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    check_eq({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    issue(1'b0, 32'd100, 32'd7);
    await("u100_7", 33);
    tick();
    check_eq("done_pulse_end", {31'd0, done}, 32'd0);

    issue(1'b1, -32'sd100, 32'd7);
    await("s_m100_7", 33);
    issue(1'b1, 32'd100, -32'sd7);
    await("s_100_m7", 33);
    issue(1'b1, -32'sd100, -32'sd7);
    await("s_m100_m7", 33);

    issue(1'b0, 32'h1234_5678, 32'd0);
    await("dbz_u", 1);
    issue(1'b1, 32'h8000_0000, 32'd0);
    await("dbz_prio", 1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    await("ovf_s", 1);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    await("ovf_u", 33);

    issue(1'b0, 32'd1000, 32'd9);
    for (int i = 0; i < 4; i++) tick();
    is_signed = 1'b1;
    dividend  = 32'd77;
    divisor   = 32'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    await("ignored_start", 33);
    issue(1'b1, -32'sd12345, 32'd67);
    await("back_to_back", 33);
    for (int i = 0; i < 3; i++) tick();
    check_eq("hold_quotient", quotient, last_q);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      issue(1'(i % 3 == 0), a, b);
      await("random", 33);
    end

    issue(1'b0, 32'hFFFF_FFFF, 32'd3);
    void'(sb.pop_back());
    while (cyc - e0 < 9) tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_eq("no_done_after_abort", 32'(done_seen), 32'd0);
    issue(1'b0, 32'd50, 32'd5);
    await("after_reset_50_5", 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
